// File: rtl/keypad_events.sv
// ---------------------------------------------------------------------------
// keypad_events
//
// Debounces the 16-bit raw key vector from the hex keypad scanner, one
// independent counter per key, and turns stable-state changes into one-cycle
// press/release pulses. It also serves the CPU's key instructions: an indexed
// zero-latency query for the skip tests, and a request/done handshake for the
// blocking wait-for-key, which reports a key only after it has been pressed
// and then released.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   raw_keys[15:0] raw pressed-key vector from the scanner (same clock domain)
//   keys[15:0]     debounced stable key vector
//   press_evt      one-cycle pulse per key on a stable 0->1 transition
//   release_evt    one-cycle pulse per key on a stable 1->0 transition
//   any_pressed    OR of keys (combinational)
//   query_idx[3:0] key index for skip tests
//   query_pressed  keys[query_idx] (combinational)
//   wait_req       level, held high by the CPU while waiting for a key
//   wait_done      registered; high while wait_key holds a valid result
//   wait_key[3:0]  registered; index of the pressed-then-released key
// ---------------------------------------------------------------------------
module keypad_events #(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int CNT_W           = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] raw_keys,
    output logic [15:0] keys,
    output logic [15:0] press_evt,
    output logic [15:0] release_evt,
    output logic        any_pressed,
    input  logic [3:0]  query_idx,
    output logic        query_pressed,
    input  logic        wait_req,
    output logic        wait_done,
    output logic [3:0]  wait_key
);

    // Counter value at which the next mismatching edge flips the stable state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0] keys_q;
    logic [15:0] press_evt_q;
    logic [15:0] release_evt_q;

    // -----------------------------------------------------------------------
    // Per-key debounce. Any edge where raw agrees with the stable state
    // restarts the count, so only an unbroken run of DEBOUNCE_CYCLES
    // mismatching edges flips the key. The counter is cleared at the terminal
    // value, so it never wraps.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_key
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             key_q, key_d;
            logic             press_q, press_d;
            logic             release_q, release_d;

            always_comb begin
                cnt_d     = cnt_q;
                key_d     = key_q;
                press_d   = 1'b0;
                release_d = 1'b0;
                if (raw_keys[gi] == key_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    key_d     = ~key_q;
                    cnt_d     = '0;
                    // Event flops load together with the flip, so the pulse
                    // lines up with the cycle keys first shows the new value.
                    press_d   = ~key_q;
                    release_d = key_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q     <= '0;
                    key_q     <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    cnt_q     <= cnt_d;
                    key_q     <= key_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                end
            end

            assign keys_q[gi]        = key_q;
            assign press_evt_q[gi]   = press_q;
            assign release_evt_q[gi] = release_q;
        end
    endgenerate

    assign keys          = keys_q;
    assign press_evt     = press_evt_q;
    assign release_evt   = release_evt_q;
    assign any_pressed   = |keys_q;
    assign query_pressed = keys_q[query_idx];

    // -----------------------------------------------------------------------
    // Wait-for-key FSM. Works purely from the press/release pulses, so keys
    // already held when the wait starts are never reported.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_key_q, wait_key_d;
    logic        wait_done_q, wait_done_d;
    logic [3:0]  low_idx;

    // Lowest set press bit; scanned downwards so the lowest index wins.
    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (press_evt_q[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_key_d = wait_key_q;
        case (state_q)
            ST_IDLE: begin
                if (wait_req) begin
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                // Abort is checked first so a dropped request beats a capture.
                if (!wait_req) begin
                    state_d = ST_IDLE;
                end else if (|press_evt_q) begin
                    wait_key_d = low_idx;
                    state_d    = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!wait_req) begin
                    state_d = ST_IDLE;
                end else if (release_evt_q[wait_key_q]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!wait_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered alongside the state so wait_done tracks DONE exactly.
        wait_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_key_q  <= 4'd0;
            wait_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_key_q  <= wait_key_d;
            wait_done_q <= wait_done_d;
        end
    end

    assign wait_done = wait_done_q;
    assign wait_key  = wait_key_q;

endmodule

// File: tb/tb_keypad_events.sv
// ---------------------------------------------------------------------------
// tb_keypad_events
//
// Directed bench for keypad_events with DEBOUNCE_CYCLES=4. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_keypad_events;

    logic        clk;
    logic        rst;
    logic [15:0] raw_keys;
    logic [15:0] keys;
    logic [15:0] press_evt;
    logic [15:0] release_evt;
    logic        any_pressed;
    logic [3:0]  query_idx;
    logic        query_pressed;
    logic        wait_req;
    logic        wait_done;
    logic [3:0]  wait_key;

    int n_vec;
    int n_miss;

    keypad_events #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (13)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_keys     (raw_keys),
        .keys         (keys),
        .press_evt    (press_evt),
        .release_evt  (release_evt),
        .any_pressed  (any_pressed),
        .query_idx    (query_idx),
        .query_pressed(query_pressed),
        .wait_req     (wait_req),
        .wait_done    (wait_done),
        .wait_key     (wait_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        raw_keys  = 16'hFFFF;
        query_idx = 4'd0;
        wait_req  = 1'b0;

        // Reset holds everything at zero even with all raw keys pressed.
        tick(2);
        check_vec("rst_keys", keys, 16'h0000);
        check_vec("rst_press", press_evt, 16'h0000);
        check_vec("rst_release", release_evt, 16'h0000);
        check_vec("rst_wait_done", {15'd0, wait_done}, 16'h0000);
        check_vec("rst_wait_key", {12'd0, wait_key}, 16'h0000);

        // All keys flip on exactly the 4th edge after reset is released.
        rst = 1'b0;
        tick(3);
        check_vec("all_edge3_keys", keys, 16'h0000);
        tick(1);
        check_vec("all_edge4_keys", keys, 16'hFFFF);
        check_vec("all_edge4_press", press_evt, 16'hFFFF);
        raw_keys = 16'h0000;
        tick(1);
        check_vec("all_press_gone", press_evt, 16'h0000);
        tick(3);
        check_vec("all_rel_keys", keys, 16'h0000);
        check_vec("all_rel_evt", release_evt, 16'hFFFF);
        tick(1);
        check_vec("all_rel_gone", release_evt, 16'h0000);

        // Press key 5.
        raw_keys = 16'h0020;
        tick(3);
        check_vec("k5_edge3_keys", keys, 16'h0000);
        tick(1);
        check_vec("k5_edge4_keys", keys, 16'h0020);
        check_vec("k5_press", press_evt, 16'h0020);
        tick(1);
        check_vec("k5_press_1cyc", press_evt, 16'h0000);

        // A 3-cycle glitch on key 7 must be rejected.
        raw_keys = 16'h00A0;
        tick(3);
        raw_keys = 16'h0020;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_vec("glitch_keys", keys, 16'h0020);
            check_vec("glitch_press", press_evt, 16'h0000);
        end

        // Release key 5.
        raw_keys = 16'h0000;
        tick(3);
        check_vec("k5_rel_edge3", keys, 16'h0020);
        tick(1);
        check_vec("k5_rel_keys", keys, 16'h0000);
        check_vec("k5_rel_evt", release_evt, 16'h0020);
        tick(1);
        check_vec("k5_rel_1cyc", release_evt, 16'h0000);

        // Query keys 0 and 15 held.
        raw_keys = 16'h8001;
        tick(5);
        check_vec("q_keys", keys, 16'h8001);
        check_vec("q_any", {15'd0, any_pressed}, 16'h0001);
        query_idx = 4'd0;
        #1;
        check_vec("q_idx0", {15'd0, query_pressed}, 16'h0001);
        query_idx = 4'd15;
        #1;
        check_vec("q_idx15", {15'd0, query_pressed}, 16'h0001);
        query_idx = 4'd7;
        #1;
        check_vec("q_idx7", {15'd0, query_pressed}, 16'h0000);

        // Drop 0/15, hold key 3 before the wait starts.
        raw_keys = 16'h0008;
        tick(6);
        check_vec("k3_held", keys, 16'h0008);

        // FX0A: start wait, press 9 and 2 together.
        wait_req = 1'b1;
        tick(1);
        raw_keys = 16'h020C;
        tick(4);
        check_vec("fx_press", press_evt, 16'h0204);
        check_vec("fx_done_pre", {15'd0, wait_done}, 16'h0000);
        tick(1);
        check_vec("fx_wait_key", {12'd0, wait_key}, 16'h0002);
        check_vec("fx_done_cap", {15'd0, wait_done}, 16'h0000);

        // Release key 9 only: no result.
        raw_keys = 16'h000C;
        tick(4);
        check_vec("fx_rel9_evt", release_evt, 16'h0200);
        tick(2);
        check_vec("fx_rel9_done", {15'd0, wait_done}, 16'h0000);

        // Release key 2: done one cycle after its release pulse.
        raw_keys = 16'h0008;
        tick(4);
        check_vec("fx_rel2_evt", release_evt, 16'h0004);
        check_vec("fx_rel2_done0", {15'd0, wait_done}, 16'h0000);
        tick(1);
        check_vec("fx_done", {15'd0, wait_done}, 16'h0001);
        check_vec("fx_done_key", {12'd0, wait_key}, 16'h0002);
        tick(2);
        check_vec("fx_done_hold", {15'd0, wait_done}, 16'h0001);
        wait_req = 1'b0;
        tick(1);
        check_vec("fx_done_clear", {15'd0, wait_done}, 16'h0000);

        // Abort during WAIT_RELEASE.
        tick(1);
        wait_req = 1'b1;
        tick(1);
        raw_keys = 16'h0018;
        tick(5);
        check_vec("ab_wait_key", {12'd0, wait_key}, 16'h0004);
        wait_req = 1'b0;
        raw_keys = 16'h0008;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check_vec("ab_done_low", {15'd0, wait_done}, 16'h0000);
        end

        // Reset during WAIT_PRESS with key 3 still held.
        wait_req = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        check_vec("mrst_keys", keys, 16'h0000);
        check_vec("mrst_press", press_evt, 16'h0000);
        check_vec("mrst_release", release_evt, 16'h0000);
        check_vec("mrst_done", {15'd0, wait_done}, 16'h0000);
        check_vec("mrst_wait_key", {12'd0, wait_key}, 16'h0000);
        check_vec("mrst_any", {15'd0, any_pressed}, 16'h0000);
        rst      = 1'b0;
        wait_req = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/keypad_events.md
Name: keypad_events

Overview:
- Sits directly downstream of the hex keypad scanner; consumes its 16-bit raw pressed-key vector (bit n = key n, 1 = pressed).
- Debounces each key independently and emits a stable key vector plus one-cycle press/release event pulses.
- Serves the CPU's key instructions:
  - EX9E/EXA1 skip tests through an indexed query.
  - FX0A wait-for-key through a request/done handshake with press-then-release semantics.

Parameters:
- DEBOUNCE_CYCLES, 4096: consecutive mismatching cycles required before a key's stable state flips. Legal range 1 .. 2^CNT_W-1.
- CNT_W, 13: width of each per-key debounce counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- raw_keys  input  16  raw key vector from the scanner, same clock domain, no synchronizer.
- keys  output  16  debounced stable key vector.
- press_evt  output  16  bit n high for exactly one cycle when keys[n] goes 0->1.
- release_evt  output  16  bit n high for exactly one cycle when keys[n] goes 1->0.
- any_pressed  output  1  OR of keys, combinational.
- query_idx  input  4  key index for skip tests.
- query_pressed  output  1  keys[query_idx], combinational, zero latency.
- wait_req  input  1  level; CPU holds high while executing FX0A.
- wait_done  output  1  high while the result is valid; registered.
- wait_key  output  4  captured key index; valid while wait_done=1; registered.

Behaviour:
- Reset: when rst=1 at an edge:
  - keys, press_evt, release_evt, all counters, wait_key and wait_done are cleared to 0.
  - FSM goes to IDLE.
  - rst has priority over all other activity, including mid-debounce and mid-wait.
- Debounce, per key i, each edge:
  - If raw_keys[i]==keys[i], cnt[i] is cleared to 0.
  - Otherwise, if cnt[i]==DEBOUNCE_CYCLES-1, keys[i] is inverted and cnt[i] is cleared.
  - Otherwise cnt[i] increments.
  - keys[i] therefore flips on the DEBOUNCE_CYCLES-th consecutive edge at which raw differs from stable. With DEBOUNCE_CYCLES=1 it flips on the first such edge.
  - Any single agreeing cycle restarts the count (glitch rejection).
  - The counter never wraps, because it is cleared at the terminal value.
- Events:
  - press_evt[i] and release_evt[i] are registered at the same edge keys[i] flips, and are high for exactly that one cycle.
  - Multiple keys may flip in the same cycle, producing multiple event bits.
  - A press and a release of the same key can never coincide.
- Wait FSM, states IDLE, WAIT_PRESS, WAIT_RELEASE, DONE:
  - IDLE: wait_done=0. If wait_req=1, go to WAIT_PRESS.
  - WAIT_PRESS:
    - Keys already held when the wait began are ignored; only new press_evt bits count.
    - On any press_evt bit, capture the lowest set index into wait_key and go to WAIT_RELEASE.
    - If wait_req=0, go to IDLE.
  - WAIT_RELEASE:
    - When release_evt[wait_key]=1, go to DONE.
    - Presses and releases of other keys are ignored.
    - If wait_req=0, go to IDLE with no result.
  - DONE: wait_done=1 and wait_key is held. When wait_req=0, go to IDLE, and wait_done is 0 from the next cycle.
  - Abort (wait_req dropping) takes priority over a same-cycle capture or release.
  - A new wait requires passing through IDLE, so wait_req must be low for at least one cycle between waits.
- Latency:
  - Raw edge to keys/event: DEBOUNCE_CYCLES edges.
  - Release event to wait_done=1: 1 cycle.

Test Plan:
- Reset and idle (DEBOUNCE_CYCLES=4): hold rst=1 for 2 cycles with raw_keys=16'hFFFF -> keys=0, press_evt=0, release_evt=0, wait_done=0; after release, keys=16'hFFFF exactly 4 edges later.
- Debounce: raw_keys=16'h0020 held -> keys[5] rises on the 4th edge with press_evt=16'h0020 for 1 cycle. A 3-cycle pulse on bit 7 -> keys unchanged, no event.
- Release: after the previous case, raw_keys=0 -> release_evt=16'h0020 for 1 cycle on the 4th edge, keys=0.
- Query: keys=16'h8001 stable; query_idx=0 -> query_pressed=1; query_idx=15 -> 1; query_idx=7 -> 0, same cycle.
- FX0A:
  - Key 3 is held before wait_req=1; then keys 9 and 2 are pressed in the same cycle -> wait_key=2.
  - Releasing key 9 leaves wait_done at 0; releasing key 2 sets wait_done=1 one cycle later with wait_key=2.
  - Dropping wait_req clears wait_done the next cycle.
- Abort and reset mid-wait:
  - wait_req drops during WAIT_RELEASE -> IDLE, wait_done never rises.
  - rst pulsed during WAIT_PRESS -> IDLE and all outputs 0.
